// File: rtl/digit_counter.sv
// digit_counter
// Multi-digit cascaded modulo counter. DIGITS digits of base MODULUS are held
// in one packed register. The register supports count up/down, parallel load,
// synchronous clear and an asynchronous clear. A combinational terminal count
// (cout) lets several blocks be chained.
//
// Ports:
//   clk    rising-edge clock
//   clr_n  asynchronous active-low clear, all digits to 0
//   sclr   synchronous clear (highest synchronous priority)
//   ce     count enable
//   up     direction, 1 = increment, 0 = decrement
//   load   synchronous parallel load; invalid digits (>= MODULUS) load as 0
//   din    load value, digit 0 in din[DIGIT_W-1:0]
//   data   registered count, same packing as din
//   cout   combinational terminal count (ce & up & all max, or ce & ~up & all 0)
//   zero   combinational, all digits == 0
//
// Build option: define DIGIT_COUNTER_SAT_EN to saturate at the end of range
// instead of wrapping. cout behaves the same in both builds.
module digit_counter #(
    parameter int unsigned DIGITS  = 4,
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic                        clk,
    input  logic                        clr_n,
    input  logic                        sclr,
    input  logic                        ce,
    input  logic                        up,
    input  logic                        load,
    input  logic [DIGITS*DIGIT_W-1:0]   din,
    output logic [DIGITS*DIGIT_W-1:0]   data,
    output logic                        cout,
    output logic                        zero
);

    localparam int unsigned TOTAL_W = DIGITS * DIGIT_W;
    localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MODULUS - 1);
    // One extra bit so MODULUS itself (which may equal 2^DIGIT_W) is representable.
    localparam logic [DIGIT_W:0]   MOD_V = (DIGIT_W + 1)'(MODULUS);

`ifdef DIGIT_COUNTER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic               all_max;
    logic               all_zero;
    logic               run;
    logic [DIGIT_W-1:0] d_cur;
    logic [DIGIT_W-1:0] d_ld;
    logic [TOTAL_W-1:0] cnt_val;
    logic [TOTAL_W-1:0] ld_val;
    logic [TOTAL_W-1:0] data_nxt;

    // Whole-chain terminal flags.
    always_comb begin
        all_max  = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (data[i*DIGIT_W +: DIGIT_W] != MAX_D) all_max  = 1'b0;
            if (data[i*DIGIT_W +: DIGIT_W] != '0)    all_zero = 1'b0;
        end
    end

    assign zero = all_zero;
    assign cout = ce & (up ? all_max : all_zero);

    // Next count, sanitised load value and clear/load/count priority.
    always_comb begin
        cnt_val  = data;
        ld_val   = '0;
        data_nxt = data;
        run      = 1'b1;
        d_cur    = '0;
        d_ld     = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d_cur = data[i*DIGIT_W +: DIGIT_W];
            // run: every lower digit is at its rollover value, so this digit steps.
            if (run) begin
                if (up) begin
                    cnt_val[i*DIGIT_W +: DIGIT_W] = (d_cur == MAX_D) ? '0 : d_cur + DIGIT_W'(1);
                end else begin
                    cnt_val[i*DIGIT_W +: DIGIT_W] = (d_cur == '0) ? MAX_D : d_cur - DIGIT_W'(1);
                end
            end
            run = run & (up ? (d_cur == MAX_D) : (d_cur == '0));

            d_ld = din[i*DIGIT_W +: DIGIT_W];
            ld_val[i*DIGIT_W +: DIGIT_W] = ({1'b0, d_ld} < MOD_V) ? d_ld : '0;
        end

        // At the end of range, a saturating build holds instead of wrapping.
        if (SAT_EN && cout) begin
            cnt_val = data;
        end

        if (sclr) begin
            data_nxt = '0;
        end else if (load) begin
            data_nxt = ld_val;
        end else if (ce) begin
            data_nxt = cnt_val;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            data <= '0;
        end else begin
            data <= data_nxt;
        end
    end

endmodule
